// File: rtl/operand_sequencer_pkg.sv
// Shared encodings and constant-generator table for the MSP430 operand sequencer.
package operand_sequencer_pkg;

    localparam int MAX_W = 20;

    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_CG1 = 4'd2;
    localparam logic [3:0] REG_CG2 = 4'd3;

    localparam logic [1:0] AS_REG = 2'b00;
    localparam logic [1:0] AS_IDX = 2'b01;
    localparam logic [1:0] AS_IND = 2'b10;
    localparam logic [1:0] AS_INC = 2'b11;
    localparam logic       AD_IDX = 1'b1;

    typedef enum logic [1:0] {
        FMT_TWO     = 2'd0,
        FMT_SINGLE  = 2'd1,
        FMT_JUMP    = 2'd2,
        FMT_ILLEGAL = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FSRC = 2'd1,
        ST_FDST = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic logic cg_src_gen(input logic [3:0] rn, input logic [1:0] as_mode);
        return (rn == REG_CG2) || (rn == REG_CG1 && as_mode != AS_REG);
    endfunction

    // Source-side constant table; the -1 entry is all-ones in data_w bits.
    function automatic logic [MAX_W-1:0] cg_src_val(input logic [3:0] rn, input logic [1:0] as_mode,
                                                    input int data_w);
        logic [MAX_W-1:0] ones;
        logic [MAX_W-1:0] val;
        for (int i = 0; i < MAX_W; i++) ones[i] = (i < data_w);
        val = '0;
        if (rn == REG_CG2) begin
            case (as_mode)
                AS_REG:  val = '0;
                AS_IDX:  val = MAX_W'(1);
                AS_IND:  val = MAX_W'(2);
                default: val = ones;
            endcase
        end else if (rn == REG_CG1) begin
            case (as_mode)
                AS_IND:  val = MAX_W'(4);
                AS_INC:  val = MAX_W'(8);
                default: val = '0;
            endcase
        end
        return val;
    endfunction

    function automatic logic cg_dst_gen(input logic [3:0] rn, input logic ad);
        return (rn == REG_CG2) || (rn == REG_CG1 && ad == AD_IDX);
    endfunction

    function automatic logic [MAX_W-1:0] cg_dst_val(input logic [3:0] rn, input logic ad);
        return (rn == REG_CG2 && ad == AD_IDX) ? MAX_W'(1) : '0;
    endfunction

endpackage

// File: rtl/operand_sequencer_decode.sv
// Combinational instruction-word decode: format, constant generation, extension-word needs.
module operand_decode
    import operand_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit ABS_EXT = 1'b1
) (
    input  logic [15:0]       iw,
    output fmt_e              fmt,
    output logic              src_gen,
    output logic [DATA_W-1:0] src_val,
    output logic              dst_gen,
    output logic [DATA_W-1:0] dst_val,
    output logic              src_need,
    output logic              dst_need
);

    logic [3:0] src_reg;
    logic [3:0] dst_reg;
    logic [1:0] as_mode;
    logic       ad;
    logic       unused_iw6;

    assign src_reg    = iw[11:8];
    assign dst_reg    = iw[3:0];
    assign as_mode    = iw[5:4];
    assign ad         = iw[7];
    assign unused_iw6 = iw[6];

    // CG1 in indexed mode is absolute addressing, which only fetches a word when ABS_EXT is set.
    function automatic logic as_needs_ext(input logic [3:0] rn, input logic [1:0] am);
        return (am == AS_IDX && rn != REG_CG2 && (rn != REG_CG1 || ABS_EXT)) ||
               (am == AS_INC && rn == REG_PC);
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        fmt      = FMT_TWO;
        src_gen  = 1'b0;
        src_val  = '0;
        dst_gen  = 1'b0;
        dst_val  = '0;
        src_need = 1'b0;
        dst_need = 1'b0;
        casez (iw[15:12])
            4'b0000: fmt = FMT_ILLEGAL;
            4'b0001: begin
                fmt      = FMT_SINGLE;
                dst_gen  = cg_src_gen(dst_reg, as_mode);
                dst_val  = DATA_W'(cg_src_val(dst_reg, as_mode, DATA_W));
                dst_need = as_needs_ext(dst_reg, as_mode);
            end
            4'b001?: fmt = FMT_JUMP;
            default: begin
                fmt      = FMT_TWO;
                src_gen  = cg_src_gen(src_reg, as_mode);
                src_val  = DATA_W'(cg_src_val(src_reg, as_mode, DATA_W));
                src_need = as_needs_ext(src_reg, as_mode);
                dst_gen  = cg_dst_gen(dst_reg, ad);
                dst_val  = DATA_W'(cg_dst_val(dst_reg, ad));
                dst_need = (ad == AD_IDX) && dst_reg != REG_CG2 && (dst_reg != REG_CG1 || ABS_EXT);
            end
        endcase
    end

endmodule

// File: rtl/operand_sequencer.sv
// Accepts an instruction word, fetches source then destination extension words, holds the result.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit ABS_EXT = 1'b1
) (
    input  logic              MCLK,
    input  logic              RSTn,
    input  logic              iw_valid,
    output logic              iw_ready,
    input  logic [15:0]       iw,
    input  logic              flush,
    output logic              ext_req,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        fmt,
    output logic [DATA_W-1:0] src_val,
    output logic [DATA_W-1:0] dst_val,
    output logic              src_gen,
    output logic              dst_gen,
    output logic [DATA_W-1:0] src_ext,
    output logic [DATA_W-1:0] dst_ext,
    output logic              src_has_ext,
    output logic              dst_has_ext
);

    fmt_e              dec_fmt;
    logic              dec_src_gen, dec_dst_gen, dec_src_need, dec_dst_need;
    logic [DATA_W-1:0] dec_src_val, dec_dst_val;

    operand_decode #(.DATA_W(DATA_W), .ABS_EXT(ABS_EXT)) u_decode (
        .iw       (iw),
        .fmt      (dec_fmt),
        .src_gen  (dec_src_gen),
        .src_val  (dec_src_val),
        .dst_gen  (dec_dst_gen),
        .dst_val  (dec_dst_val),
        .src_need (dec_src_need),
        .dst_need (dec_dst_need)
    );

    state_e            state_q, state_d;
    fmt_e              fmt_q, fmt_d;
    logic [DATA_W-1:0] src_val_q, src_val_d, dst_val_q, dst_val_d;
    logic [DATA_W-1:0] src_ext_q, src_ext_d, dst_ext_q, dst_ext_d;
    logic              src_gen_q, src_gen_d, dst_gen_q, dst_gen_d;
    logic              src_has_q, src_has_d, dst_has_q, dst_has_d;
    logic              need_dst_q, need_dst_d;
    logic              iw_ready_q, iw_ready_d, op_valid_q, op_valid_d, ext_req_q, ext_req_d;

    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        src_val_d  = src_val_q;
        dst_val_d  = dst_val_q;
        src_ext_d  = src_ext_q;
        dst_ext_d  = dst_ext_q;
        src_gen_d  = src_gen_q;
        dst_gen_d  = dst_gen_q;
        src_has_d  = src_has_q;
        dst_has_d  = dst_has_q;
        need_dst_d = need_dst_q;
        case (state_q)
            ST_IDLE: if (iw_valid) begin
                fmt_d      = dec_fmt;
                src_val_d  = dec_src_val;
                dst_val_d  = dec_dst_val;
                src_gen_d  = dec_src_gen;
                dst_gen_d  = dec_dst_gen;
                src_ext_d  = '0;
                dst_ext_d  = '0;
                src_has_d  = 1'b0;
                dst_has_d  = 1'b0;
                need_dst_d = dec_dst_need;
                state_d    = dec_src_need ? ST_FSRC : (dec_dst_need ? ST_FDST : ST_HOLD);
            end
            ST_FSRC: if (ext_ack) begin
                src_ext_d = ext_data;
                src_has_d = 1'b1;
                state_d   = need_dst_q ? ST_FDST : ST_HOLD;
            end
            ST_FDST: if (ext_ack) begin
                dst_ext_d = ext_data;
                dst_has_d = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: if (op_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides any ack or op_ready arriving in the same cycle.
        if (flush) begin
            state_d    = ST_IDLE;
            fmt_d      = FMT_TWO;
            src_val_d  = '0;
            dst_val_d  = '0;
            src_ext_d  = '0;
            dst_ext_d  = '0;
            src_gen_d  = 1'b0;
            dst_gen_d  = 1'b0;
            src_has_d  = 1'b0;
            dst_has_d  = 1'b0;
            need_dst_d = 1'b0;
        end
        iw_ready_d = (state_d == ST_IDLE);
        op_valid_d = (state_d == ST_HOLD);
        ext_req_d  = (state_d == ST_FSRC) || (state_d == ST_FDST);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MCLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            fmt_q      <= FMT_TWO;
            src_val_q  <= '0;
            dst_val_q  <= '0;
            src_ext_q  <= '0;
            dst_ext_q  <= '0;
            src_gen_q  <= 1'b0;
            dst_gen_q  <= 1'b0;
            src_has_q  <= 1'b0;
            dst_has_q  <= 1'b0;
            need_dst_q <= 1'b0;
            iw_ready_q <= 1'b1;
            op_valid_q <= 1'b0;
            ext_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fmt_q      <= fmt_d;
            src_val_q  <= src_val_d;
            dst_val_q  <= dst_val_d;
            src_ext_q  <= src_ext_d;
            dst_ext_q  <= dst_ext_d;
            src_gen_q  <= src_gen_d;
            dst_gen_q  <= dst_gen_d;
            src_has_q  <= src_has_d;
            dst_has_q  <= dst_has_d;
            need_dst_q <= need_dst_d;
            iw_ready_q <= iw_ready_d;
            op_valid_q <= op_valid_d;
            ext_req_q  <= ext_req_d;
        end
    end

    assign iw_ready    = iw_ready_q;
    assign op_valid    = op_valid_q;
    assign ext_req     = ext_req_q;
    assign fmt         = fmt_q;
    assign src_val     = src_val_q;
    assign dst_val     = dst_val_q;
    assign src_gen     = src_gen_q;
    assign dst_gen     = dst_gen_q;
    assign src_ext     = src_ext_q;
    assign dst_ext     = dst_ext_q;
    assign src_has_ext = src_has_q;
    assign dst_has_ext = dst_has_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: 16-bit, 20-bit and ABS_EXT=0 instances on shared stimulus.
module tb_operand_sequencer;

    logic        MCLK, RSTn, iw_valid, flush, ext_ack, op_ready;
    logic [15:0] iw, ext_data;
    logic [19:0] ext_data20;

    logic        a_iw_ready, a_ext_req, a_op_valid, a_src_gen, a_dst_gen, a_src_has, a_dst_has;
    logic [1:0]  a_fmt;
    logic [15:0] a_src_val, a_dst_val, a_src_ext, a_dst_ext;

    logic        b_iw_ready, b_ext_req, b_op_valid, b_src_gen, b_dst_gen, b_src_has, b_dst_has;
    logic [1:0]  b_fmt;
    logic [19:0] b_src_val, b_dst_val, b_src_ext, b_dst_ext;

    logic        c_iw_ready, c_ext_req, c_op_valid, c_src_gen, c_dst_gen, c_src_has, c_dst_has;
    logic [1:0]  c_fmt;
    logic [15:0] c_src_val, c_dst_val, c_src_ext, c_dst_ext;

    int checks   = 0;
    int failures = 0;
    int a_req_cycles = 0;
    int req_base;

    operand_sequencer u16 (
        .MCLK(MCLK), .RSTn(RSTn), .iw_valid(iw_valid), .iw_ready(a_iw_ready), .iw(iw),
        .flush(flush), .ext_req(a_ext_req), .ext_ack(ext_ack), .ext_data(ext_data),
        .op_valid(a_op_valid), .op_ready(op_ready), .fmt(a_fmt),
        .src_val(a_src_val), .dst_val(a_dst_val), .src_gen(a_src_gen), .dst_gen(a_dst_gen),
        .src_ext(a_src_ext), .dst_ext(a_dst_ext), .src_has_ext(a_src_has), .dst_has_ext(a_dst_has)
    );

    operand_sequencer #(.DATA_W(20)) u20 (
        .MCLK(MCLK), .RSTn(RSTn), .iw_valid(iw_valid), .iw_ready(b_iw_ready), .iw(iw),
        .flush(flush), .ext_req(b_ext_req), .ext_ack(ext_ack), .ext_data(ext_data20),
        .op_valid(b_op_valid), .op_ready(op_ready), .fmt(b_fmt),
        .src_val(b_src_val), .dst_val(b_dst_val), .src_gen(b_src_gen), .dst_gen(b_dst_gen),
        .src_ext(b_src_ext), .dst_ext(b_dst_ext), .src_has_ext(b_src_has), .dst_has_ext(b_dst_has)
    );

    operand_sequencer #(.ABS_EXT(1'b0)) unx (
        .MCLK(MCLK), .RSTn(RSTn), .iw_valid(iw_valid), .iw_ready(c_iw_ready), .iw(iw),
        .flush(flush), .ext_req(c_ext_req), .ext_ack(ext_ack), .ext_data(ext_data),
        .op_valid(c_op_valid), .op_ready(op_ready), .fmt(c_fmt),
        .src_val(c_src_val), .dst_val(c_dst_val), .src_gen(c_src_gen), .dst_gen(c_dst_gen),
        .src_ext(c_src_ext), .dst_ext(c_dst_ext), .src_has_ext(c_src_has), .dst_has_ext(c_dst_has)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) if (a_ext_req) a_req_cycles++;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] word);
        iw       = word;
        iw_valid = 1'b1;
        tick;
        iw_valid = 1'b0;
    endtask

    task automatic release_op;
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
    endtask

    initial begin
        RSTn = 1'b1; iw_valid = 1'b0; flush = 1'b0; ext_ack = 1'b0; op_ready = 1'b0;
        iw = '0; ext_data = '0; ext_data20 = '0;
        #1 RSTn = 1'b0;
        repeat (2) @(posedge MCLK);
        #1;
        check("rst_op_valid", a_op_valid, 0);
        check("rst_ext_req", a_ext_req, 0);
        check("rst_fmt", a_fmt, 0);
        check("rst_src_val", a_src_val, 0);
        check("rst_dst_has", a_dst_has, 0);
        RSTn = 1'b1;
        tick;
        check("rel_iw_ready", a_iw_ready, 1);

        // Two constant-generator operands, no extension words.
        accept(16'h4303);
        check("4303_op_valid", a_op_valid, 1);
        check("4303_ext_req", a_ext_req, 0);
        check("4303_iw_ready", a_iw_ready, 0);
        check("4303_fmt", a_fmt, 0);
        check("4303_src_gen", a_src_gen, 1);
        check("4303_src_val", a_src_val, 16'h0000);
        check("4303_dst_gen", a_dst_gen, 1);
        check("4303_dst_val", a_dst_val, 16'h0000);
        op_ready = 1'b1; iw_valid = 1'b1;
        tick;
        op_ready = 1'b0; iw_valid = 1'b0;
        check("4303_ret_op_valid", a_op_valid, 0);
        check("4303_ret_no_accept", a_iw_ready, 1);

        // Immediate source, ack after two wait cycles.
        accept(16'h4034);
        check("4034_ext_req", a_ext_req, 1);
        check("4034_op_valid_c1", a_op_valid, 0);
        tick;
        tick;
        check("4034_ext_req_held", a_ext_req, 1);
        check("4034_op_valid_c3", a_op_valid, 0);
        ext_ack = 1'b1; ext_data = 16'h1234; ext_data20 = 20'h01234;
        tick;
        ext_ack = 1'b0;
        check("4034_op_valid_c4", a_op_valid, 1);
        check("4034_ext_req_drop", a_ext_req, 0);
        check("4034_src_ext", a_src_ext, 16'h1234);
        check("4034_src_has", a_src_has, 1);
        check("4034_src_gen", a_src_gen, 0);
        check("4034_dst_has", a_dst_has, 0);
        release_op;

        // CG1 constant source and CG1 absolute destination.
        req_base = a_req_cycles;
        accept(16'h42B2);
        check("42B2_ext_req", a_ext_req, 1);
        check("42B2_op_valid_wait", a_op_valid, 0);
        check("42B2_nx_op_valid", c_op_valid, 1);
        check("42B2_nx_ext_req", c_ext_req, 0);
        check("42B2_nx_dst_gen", c_dst_gen, 1);
        check("42B2_nx_src_val", c_src_val, 8);
        ext_ack = 1'b1; ext_data = 16'h0200;
        tick;
        ext_ack = 1'b0;
        check("42B2_op_valid", a_op_valid, 1);
        check("42B2_src_gen", a_src_gen, 1);
        check("42B2_src_val", a_src_val, 16'h0008);
        check("42B2_dst_gen", a_dst_gen, 1);
        check("42B2_dst_val", a_dst_val, 16'h0000);
        check("42B2_dst_ext", a_dst_ext, 16'h0200);
        check("42B2_dst_has", a_dst_has, 1);
        check("42B2_src_has", a_src_has, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_op_valid", a_op_valid, 1);
            check("hold_src_val", a_src_val, 16'h0008);
            check("hold_dst_ext", a_dst_ext, 16'h0200);
            check("hold_iw_ready", a_iw_ready, 0);
        end
        check("42B2_req_cycles", a_req_cycles - req_base, 1);
        flush = 1'b1; op_ready = 1'b1;
        tick;
        flush = 1'b0; op_ready = 1'b0;
        check("hflush_op_valid", a_op_valid, 0);
        check("hflush_src_val", a_src_val, 0);
        check("hflush_dst_has", a_dst_has, 0);
        check("hflush_iw_ready", a_iw_ready, 1);

        // Single-op with CG2/As11 on the 20-bit instance.
        accept(16'h1233);
        check("1233_w20_fmt", b_fmt, 1);
        check("1233_w20_dst_val", b_dst_val, 20'hFFFFF);
        check("1233_w20_dst_gen", b_dst_gen, 1);
        check("1233_w20_op_valid", b_op_valid, 1);
        check("1233_w20_src_gen", b_src_gen, 0);
        check("1233_w16_dst_val", a_dst_val, 16'hFFFF);
        release_op;

        // Jump and illegal: no extension words, no generator flags.
        accept(16'h3C30);
        check("jump_fmt", a_fmt, 2);
        check("jump_op_valid", a_op_valid, 1);
        check("jump_ext_req", a_ext_req, 0);
        check("jump_src_gen", a_src_gen, 0);
        check("jump_dst_gen", a_dst_gen, 0);
        release_op;
        accept(16'h0030);
        check("ill_fmt", a_fmt, 3);
        check("ill_op_valid", a_op_valid, 1);
        check("ill_ext_req", a_ext_req, 0);
        release_op;

        // Indexed source then destination, flushed during FDST together with an ack.
        accept(16'h4592);
        check("4592_fsrc_req", a_ext_req, 1);
        ext_ack = 1'b1; ext_data = 16'hAAAA;
        tick;
        check("4592_fdst_req", a_ext_req, 1);
        check("4592_src_ext", a_src_ext, 16'hAAAA);
        check("4592_src_has", a_src_has, 1);
        check("4592_op_valid", a_op_valid, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0; ext_ack = 1'b0;
        check("fflush_iw_ready", a_iw_ready, 1);
        check("fflush_ext_req", a_ext_req, 0);
        check("fflush_op_valid", a_op_valid, 0);
        check("fflush_dst_has", a_dst_has, 0);
        check("fflush_src_has", a_src_has, 0);
        tick;
        check("fflush_op_valid_later", a_op_valid, 0);

        // Reset in the middle of a fetch.
        accept(16'h4592);
        ext_ack = 1'b1; ext_data = 16'h5555;
        tick;
        ext_ack = 1'b0;
        check("rmid_ext_req", a_ext_req, 1);
        check("rmid_src_has", a_src_has, 1);
        RSTn = 1'b0;
        #1;
        check("rmid_ext_req_drop", a_ext_req, 0);
        check("rmid_src_ext", a_src_ext, 0);
        check("rmid_src_has", a_src_has, 0);
        check("rmid_fmt", a_fmt, 0);
        check("rmid_op_valid", a_op_valid, 0);
        #1 RSTn = 1'b1;
        tick;
        check("rmid_rel_iw_ready", a_iw_ready, 1);
        check("rmid_rel_ext_req", a_ext_req, 0);
        check("rmid_rel_op_valid", a_op_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
